axi2axis: RTL and testbench

AXI2AXIS -- requirements
Module: axi2axis

---
 rtl/axi2axis_pkg.sv | 19 +
 rtl/axi2axis.sv | 181 ++++++++++++++++++
 tb/tb_axi2axis.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi2axis_pkg.sv
// Shared constants for the AXI4 slave to AXI-Stream bridge.
//   - write/read channel FSM state encodings
//   - AXI response codes (OKAY, SLVERR)
package axi2axis_pkg;

    // Write channel FSM
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Read channel FSM
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi2axis.sv
// AXI4 slave to AXI-Stream bridge.
// A write burst (AW + W beats) is forwarded beat by beat onto the stream-out
// port with zero latency; a read burst (AR) pulls beats from the stream-in
// port and returns them as R beats. One outstanding burst per direction; the
// two directions are fully independent.
// Ports:
//   clk_i, rst_i (sync, active high), cke_i (clock enable, gates all state)
//   s_axi_aw*/w*/b*   AXI4 write slave channels
//   s_axi_ar*/r*      AXI4 read slave channels
//   axis_out_*        stream-out (write data), axis_out_addr_o = latched awaddr
//   axis_in_*         stream-in  (read data),  axis_in_addr_o  = latched araddr
module axi2axis
    import axi2axis_pkg::*;
#(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cke_i,

    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    output logic [AXI_DATA_W-1:0]   axis_out_data_o,
    output logic                    axis_out_last_o,
    output logic                    axis_out_valid_o,
    input  logic                    axis_out_ready_i,
    output logic [AXI_ADDR_W-1:0]   axis_out_addr_o,

    input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
    input  logic                    axis_in_valid_i,
    output logic                    axis_in_ready_o,
    output logic [AXI_ADDR_W-1:0]   axis_in_addr_o
);

    // Only full-width INCR bursts are supported; size, burst type and byte
    // strobes carry no information for this bridge.
    logic unused;
    assign unused = ^{s_axi_awsize, s_axi_awburst, s_axi_wstrb,
                      s_axi_arsize, s_axi_arburst};

    // ---------------------------------------------------------------- write
    logic [1:0]            w_state;
    logic [7:0]            w_cnt;
    logic [7:0]            aw_len;
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic                  w_err;

    logic w_in_data, w_final, w_beat, aw_hs, b_hs;

    assign w_in_data = (w_state == W_DATA);
    assign w_final   = (w_cnt == aw_len);
    assign w_beat    = w_in_data & s_axi_wvalid & axis_out_ready_i;
    assign aw_hs     = s_axi_awvalid & s_axi_awready;
    assign b_hs      = s_axi_bvalid & s_axi_bready;

    assign s_axi_awready    = (w_state == W_IDLE);
    assign s_axi_wready     = w_in_data & axis_out_ready_i;
    assign axis_out_valid_o = w_in_data & s_axi_wvalid;
    assign axis_out_data_o  = w_in_data ? s_axi_wdata : '0;
    // Burst length comes from awlen alone; wlast is only audited.
    assign axis_out_last_o  = w_in_data & w_final;
    assign axis_out_addr_o  = aw_addr;

    assign s_axi_bvalid = (w_state == W_RESP);
    assign s_axi_bid    = s_axi_bvalid ? aw_id : '0;
    assign s_axi_bresp  = (s_axi_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            aw_len  <= '0;
            aw_id   <= '0;
            aw_addr <= '0;
            w_err   <= 1'b0;
        end else if (cke_i) begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    aw_id   <= s_axi_awid;
                    aw_addr <= s_axi_awaddr;
                    aw_len  <= s_axi_awlen;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_beat) begin
                    // wlast early or missing on the final beat -> SLVERR
                    if (s_axi_wlast != w_final) w_err <= 1'b1;
                    w_cnt <= w_cnt + 8'd1;   // wraps after beat 256, harmless
                    if (w_final) w_state <= W_RESP;
                end
                W_RESP: if (b_hs) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- read
    logic [0:0]            r_state;
    logic [7:0]            r_cnt;
    logic [7:0]            ar_len;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;

    logic r_in_data, r_final, r_beat, ar_hs;

    assign r_in_data = (r_state == R_DATA);
    assign r_final   = (r_cnt == ar_len);
    assign r_beat    = r_in_data & axis_in_valid_i & s_axi_rready;
    assign ar_hs     = s_axi_arvalid & s_axi_arready;

    assign s_axi_arready   = (r_state == R_IDLE);
    assign s_axi_rvalid    = r_in_data & axis_in_valid_i;
    assign axis_in_ready_o = r_in_data & s_axi_rready;
    assign s_axi_rdata     = r_in_data ? axis_in_data_i : '0;
    assign s_axi_rlast     = r_in_data & r_final;
    assign s_axi_rresp     = RESP_OKAY;
    assign s_axi_rid       = r_in_data ? ar_id : '0;
    assign axis_in_addr_o  = ar_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            ar_len  <= '0;
            ar_id   <= '0;
            ar_addr <= '0;
        end else if (cke_i) begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    ar_id   <= s_axi_arid;
                    ar_addr <= s_axi_araddr;
                    ar_len  <= s_axi_arlen;
                    r_cnt   <= '0;
                    r_state <= R_DATA;
                end
                R_DATA: if (r_beat) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_final) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi2axis.sv
// Directed bench for axi2axis: a table of write bursts plus hand-written
// sequences for read gaps, simultaneous AW/AR, mid-burst reset and clock
// enable freeze. Inputs change on the falling edge; outputs are checked
// shortly after, well away from the rising edge.
module tb_axi2axis;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int IW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cke = 1'b1;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = 3'd2;
    logic [1:0]    awburst = 2'b01;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [DW/8-1:0] wstrb = '1;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = 3'd2;
    logic [1:0]    arburst = 2'b01;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi2axis #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW)) dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .axis_out_data_o(out_data), .axis_out_last_o(out_last),
        .axis_out_valid_o(out_valid), .axis_out_ready_i(out_ready),
        .axis_out_addr_o(out_addr),
        .axis_in_data_i(in_data), .axis_in_valid_i(in_valid),
        .axis_in_ready_o(in_ready), .axis_in_addr_o(in_addr)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue AW; leaves the bench at the falling edge after the handshake.
    task automatic send_aw(input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [IW-1:0] id);
        @(negedge clk);
        awvalid = 1'b1; awaddr = a; awlen = len; awid = id;
        #1 check("awready_idle", awready, 1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        #1 check("awready_busy", awready, 0);
        check("out_addr", out_addr, a);
    endtask

    // One W beat, present at the current falling edge, accepted at next rise.
    task automatic send_w(input logic [DW-1:0] d, input logic wl,
                          input logic exp_last);
        wvalid = 1'b1; wdata = d; wlast = wl; out_ready = 1'b1;
        #1;
        check("out_valid", out_valid, 1);
        check("out_data", out_data, d);
        check("out_last", out_last, exp_last);
        check("wready", wready, 1);
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic take_b(input logic [1:0] exp_resp, input logic [IW-1:0] exp_id);
        out_ready = 1'b0;
        bready = 1'b1;
        #1;
        check("bvalid", bvalid, 1);
        check("bresp", bresp, exp_resp);
        check("bid", bid, exp_id);
        check("out_valid_resp", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        #1;
        check("bvalid_done", bvalid, 0);
        check("awready_done", awready, 1);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        int            wlast_beat;   // beat index carrying wlast, -1 = none
        logic [DW-1:0] base;         // data of beat 0
        logic [1:0]    exp_resp;
    } wvec_t;

    wvec_t wtab[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        logic [DW-1:0] exp_d;

        wtab[0] = '{24'h000100, 8'd3,   3,  32'd1,    2'b00};  // clean burst
        wtab[1] = '{24'h000200, 8'd3,   1,  32'd101,  2'b10};  // early wlast
        wtab[2] = '{24'h000300, 8'd0,   0,  32'hA5A5, 2'b00};  // single beat
        wtab[3] = '{24'h000400, 8'd1,   -1, 32'd7,    2'b10};  // missing wlast
        wtab[4] = '{24'hABCDEF, 8'd255, 255, 32'd1000, 2'b00}; // 256 beats

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_addr", out_addr, 0);

        // ---- table of write bursts
        for (int t = 0; t < 5; t++) begin
            send_aw(wtab[t].addr, wtab[t].len, IW'(t));
            for (int i = 0; i <= int'(wtab[t].len); i++)
                send_w(wtab[t].base + DW'(i), i == wtab[t].wlast_beat,
                       i == int'(wtab[t].len));
            take_b(wtab[t].exp_resp, IW'(t));
        end

        // ---- read burst, arlen=7, random gaps on both sides
        @(negedge clk);
        arvalid = 1'b1; araddr = 24'h000800; arlen = 8'd7; arid = 1'b1;
        #1 check("arready_idle", arready, 1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        check("arready_busy", arready, 0);
        check("in_addr", in_addr, 24'h000800);
        got = 0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            in_valid = 1'($urandom_range(0, 1));
            rready   = 1'($urandom_range(0, 1));
            in_data  = 32'd10 + DW'(got);
            #1;
            check("rvalid_pass", rvalid, in_valid);
            check("in_ready_pass", in_ready, rready);
            if (in_valid && rready) begin
                check("rdata", rdata, 32'd10 + DW'(got));
                check("rlast", rlast, got == 7);
                check("rid", rid, 1);
                check("rresp", rresp, 0);
                got++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0; rready = 1'b0;
        #1;
        check("read_beats", got, 8);
        check("arready_after_read", arready, 1);
        check("rvalid_after_read", rvalid, 0);

        // ---- simultaneous AW (len 1) and AR (len 0)
        @(negedge clk);
        awvalid = 1'b1; awaddr = 24'h000500; awlen = 8'd1; awid = 1'b0;
        arvalid = 1'b1; araddr = 24'h000600; arlen = 8'd0; arid = 1'b0;
        #1;
        check("sim_awready", awready, 1);
        check("sim_arready", arready, 1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        #1;
        check("sim_aw_taken", awready, 0);
        check("sim_ar_taken", arready, 0);
        in_valid = 1'b1; in_data = 32'h55; rready = 1'b1;
        #1;
        check("sim_rvalid", rvalid, 1);
        check("sim_rdata", rdata, 32'h55);
        check("sim_rlast", rlast, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; rready = 1'b0;
        #1;
        check("sim_read_done", arready, 1);
        check("sim_write_open", awready, 0);
        send_w(32'd21, 1'b0, 1'b0);
        send_w(32'd22, 1'b1, 1'b1);
        take_b(2'b00, 1'b0);

        // ---- reset after 2 of 8 W beats
        send_aw(24'h000700, 8'd7, 1'b1);
        send_w(32'd31, 1'b0, 1'b0);
        send_w(32'd32, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wvalid = 1'b1; out_ready = 1'b1; bready = 1'b1;
        #1;
        check("mrst_awready", awready, 1);
        check("mrst_bvalid", bvalid, 0);
        check("mrst_wready", wready, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_addr", out_addr, 0);
        wvalid = 1'b0; bready = 1'b0;
        send_aw(24'h000900, 8'd0, 1'b0);
        send_w(32'd41, 1'b1, 1'b1);
        take_b(2'b00, 1'b0);

        // ---- clock enable low for 5 cycles mid-burst
        send_aw(24'h000A00, 8'd3, 1'b1);
        send_w(32'd51, 1'b0, 1'b0);
        send_w(32'd52, 1'b0, 1'b0);
        cke = 1'b0;
        // Beat 3 is held valid/ready while frozen: the counter must not move.
        for (int i = 0; i < 5; i++) begin
            wvalid = 1'b1; wdata = 32'd53; out_ready = 1'b1;
            #1;
            check("cke_out_last", out_last, 0);
            check("cke_out_valid", out_valid, 1);
            check("cke_bvalid", bvalid, 0);
            check("cke_awready", awready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        wvalid = 1'b0;
        cke = 1'b1;
        send_w(32'd53, 1'b0, 1'b0);
        send_w(32'd54, 1'b1, 1'b1);
        take_b(2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
